// File: rtl/inv_cipher_seq_pkg.sv
// Shared definitions for the iterative AES inverse cipher: FSM encoding,
// inverse S-box table and GF(2^8) arithmetic helpers.
package inv_cipher_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ROUNDS = 2'b01,
      ST_FINAL  = 2'b10
   } fsm_e;

   // Byte n of the table sits at bits [8n +: 8], so the index is simply {n, 3'b000}.
   localparam logic [0:2047] INV_SBOX_V = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic int nr_from_nk(input int nk);
      return nk + 6;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return INV_SBOX_V[{a, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = p ^ (b[i] ? x : 8'h00);
         x = xtime(x);
      end
      return p;
   endfunction

endpackage

// File: rtl/inv_cipher_seq_if.sv
// Request/response bundle between the key-schedule store, the inverse cipher
// and the plaintext consumer.
interface inv_cipher_seq_if #(
   parameter int NK = 4
) ();
   localparam int NR = inv_cipher_seq_pkg::nr_from_nk(NK);

   logic                    in_valid;
   logic                    in_ready;
   logic [0:127]            cipherText;
   logic [0:128*(NR+1)-1]   keys;
   logic [0:127]            plainText;
   logic                    done;
   logic                    busy;

   modport master (
      output in_valid, cipherText, keys,
      input  in_ready, plainText, done, busy
   );

   modport slave (
      input  in_valid, cipherText, keys,
      output in_ready, plainText, done, busy
   );
endinterface

// File: rtl/inv_cipher_seq_inv_round.sv
// One combinational inverse round: InvShiftRows -> InvSubBytes -> AddRoundKey
// -> InvMixColumns, with the column mix bypassed for the last round.
module add_round_key (
   input  logic [0:127] state_i,
   input  logic [0:127] rk_i,
   output logic [0:127] state_o
);
   assign state_o = state_i ^ rk_i;
endmodule

module inv_round
   import inv_cipher_seq_pkg::*;
(
   input  logic [0:127] state_i,
   input  logic [0:127] rk_i,
   input  logic         last_i,
   output logic [0:127] state_o
);
   logic [0:127] shr_s;
   logic [0:127] sub_s;
   logic [0:127] ark_s;
   logic [0:127] mix_s;

   // Row r rotates right by r columns; byte index is 4*column + row.
   always_comb begin
      shr_s = 128'd0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shr_s[8*(4*c+r) +: 8] = state_i[8*(4*((c-r+4)%4)+r) +: 8];
         end
      end
   end

   // Byte-wise inverse S-box substitution.
   always_comb begin
      sub_s = 128'd0;
      for (int i = 0; i < 16; i++) begin
         sub_s[8*i +: 8] = inv_sbox(shr_s[8*i +: 8]);
      end
   end

   add_round_key u_ark (
      .state_i (sub_s),
      .rk_i    (rk_i),
      .state_o (ark_s)
   );

   // Column mix by the inverse matrix rows {0e,0b,0d,09} rotated per output row.
   always_comb begin
      logic [7:0] a0, a1, a2, a3;
      mix_s = 128'd0;
      for (int c = 0; c < 4; c++) begin
         a0 = ark_s[8*(4*c)   +: 8];
         a1 = ark_s[8*(4*c+1) +: 8];
         a2 = ark_s[8*(4*c+2) +: 8];
         a3 = ark_s[8*(4*c+3) +: 8];
         mix_s[8*(4*c)   +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         mix_s[8*(4*c+1) +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         mix_s[8*(4*c+2) +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         mix_s[8*(4*c+3) +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
   end

   assign state_o = last_i ? ark_s : mix_s;
endmodule

// File: rtl/inv_cipher_seq.sv
// Iterative AES inverse cipher, one round per clock, fed by an externally
// expanded key schedule that must stay stable until done.
module inv_cipher_seq
   import inv_cipher_seq_pkg::*;
#(
   parameter int NK = 4
) (
   input logic              clk,
   input logic              reset,
   inv_cipher_seq_if.slave  bus
);
   localparam int NR = nr_from_nk(NK);

   fsm_e         fsm_q;
   logic [3:0]   round_q;
   logic [0:127] state_q;
   logic [0:127] plain_q;
   logic         done_q;

   logic [0:127] rk_a [0:NR];
   logic [0:127] rk_s;
   logic [0:127] state_d;
   logic         last_s;

   for (genvar r = 0; r <= NR; r++) begin : g_rk
      assign rk_a[r] = bus.keys[128*r +: 128];
   end

   // round_q is 0 in FINAL, so the same mux serves the last round's key[0].
   assign rk_s   = rk_a[round_q];
   assign last_s = (fsm_q == ST_FINAL);

   inv_round u_round (
      .state_i (state_q),
      .rk_i    (rk_s),
      .last_i  (last_s),
      .state_o (state_d)
   );

   // Control FSM with round counter, state register and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q   <= ST_IDLE;
         round_q <= 4'd0;
         state_q <= 128'd0;
         plain_q <= 128'd0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (fsm_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  state_q <= bus.cipherText ^ rk_a[NR];
                  round_q <= 4'(NR - 1);
                  fsm_q   <= ST_ROUNDS;
               end
            end
            ST_ROUNDS: begin
               state_q <= state_d;
               round_q <= round_q - 4'd1;
               if (round_q == 4'd1) begin
                  fsm_q <= ST_FINAL;
               end
            end
            ST_FINAL: begin
               plain_q <= state_d;
               done_q  <= 1'b1;
               fsm_q   <= ST_IDLE;
            end
            default: begin
               fsm_q   <= ST_IDLE;
               round_q <= 4'd0;
            end
         endcase
      end
   end

   assign bus.in_ready  = (fsm_q == ST_IDLE);
   assign bus.busy      = (fsm_q != ST_IDLE);
   assign bus.plainText = plain_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_inv_cipher_seq.sv
// Directed and round-trip checks of inv_cipher_seq for AES-128/192/256 against
// a forward-cipher and latency model kept in the bench.
module tb_inv_cipher_seq;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   inv_cipher_seq_if #(.NK(4)) if4 ();
   inv_cipher_seq_if #(.NK(6)) if6 ();
   inv_cipher_seq_if #(.NK(8)) if8 ();

   inv_cipher_seq #(.NK(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
   inv_cipher_seq #(.NK(6)) dut6 (.clk(clk), .reset(reset), .bus(if6));
   inv_cipher_seq #(.NK(8)) dut8 (.clk(clk), .reset(reset), .bus(if8));

   int n_checks = 0;
   int n_fail = 0;
   int nr_k [3] = '{10, 12, 14};

   logic [7:0]   sbox_t [0:255];
   logic [31:0]  w_g [0:59];
   logic [127:0] cur_exp [3];
   int           m_cnt [3];
   logic         m_done [3];
   logic [127:0] m_pt [3];
   logic [127:0] m_pend [3];

   localparam logic [255:0] KB  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [255:0] K1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K2  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PTC = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Polynomial product reduced modulo x^8+x^4+x^3+x+1 by long division.
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0000;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
   endfunction

   function automatic logic [7:0] rkb(input int r, input int i);
      logic [31:0] w;
      w = w_g[4*r + i/4];
      return w[31-8*(i%4) -: 8];
   endfunction

   task automatic expand(input logic [255:0] key, input int nk);
      logic [31:0] tmp;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w_g[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nk+7); i++) begin
         tmp = w_g[i-1];
         if (i % nk == 0) begin
            tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
            rc = gm(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            tmp = subw(tmp);
         end
         w_g[i] = w_g[i-nk] ^ tmp;
      end
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rkb(0, i);
      for (int rd = 1; rd <= nr; rd++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
         for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
         if (rd < nr) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
               t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
               t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
               t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
               t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = t[i] ^ rkb(rd, i);
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   function automatic logic get_valid(input int k);
      case (k)
         0: return if4.in_valid;
         1: return if6.in_valid;
         default: return if8.in_valid;
      endcase
   endfunction

   function automatic logic get_done(input int k);
      case (k)
         0: return if4.done;
         1: return if6.done;
         default: return if8.done;
      endcase
   endfunction

   function automatic logic get_ready(input int k);
      case (k)
         0: return if4.in_ready;
         1: return if6.in_ready;
         default: return if8.in_ready;
      endcase
   endfunction

   function automatic logic get_busy(input int k);
      case (k)
         0: return if4.busy;
         1: return if6.busy;
         default: return if8.busy;
      endcase
   endfunction

   function automatic logic [127:0] get_pt(input int k);
      case (k)
         0: return if4.plainText;
         1: return if6.plainText;
         default: return if8.plainText;
      endcase
   endfunction

   task automatic set_valid(input int k, input logic v);
      case (k)
         0: if4.in_valid = v;
         1: if6.in_valid = v;
         default: if8.in_valid = v;
      endcase
   endtask

   task automatic load(input int k, input logic [127:0] ct, input logic [127:0] exp);
      case (k)
         0: begin
            if4.cipherText = ct;
            for (int i = 0; i < 44; i++) if4.keys[32*i +: 32] = w_g[i];
         end
         1: begin
            if6.cipherText = ct;
            for (int i = 0; i < 52; i++) if6.keys[32*i +: 32] = w_g[i];
         end
         default: begin
            if8.cipherText = ct;
            for (int i = 0; i < 60; i++) if8.keys[32*i +: 32] = w_g[i];
         end
      endcase
      cur_exp[k] = exp;
   endtask

   // Model: a request taken while idle completes Nr cycles later with the expected plaintext.
   always @(posedge clk or posedge reset) begin
      for (int k = 0; k < 3; k++) begin
         if (reset) begin
            m_cnt[k]  <= 0;
            m_done[k] <= 1'b0;
            m_pt[k]   <= 128'h0;
         end else begin
            m_done[k] <= (m_cnt[k] == 1);
            if (m_cnt[k] == 1) m_pt[k] <= m_pend[k];
            if (m_cnt[k] == 0 && get_valid(k)) begin
               m_cnt[k]  <= nr_k[k];
               m_pend[k] <= cur_exp[k];
            end else if (m_cnt[k] != 0) begin
               m_cnt[k] <= m_cnt[k] - 1;
            end
         end
      end
   end

   // Compare every DUT output against the model on each falling edge.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("dut%0d_done", k),  get_done(k),  m_done[k]);
         chk($sformatf("dut%0d_ready", k), get_ready(k), m_cnt[k] == 0);
         chk($sformatf("dut%0d_busy", k),  get_busy(k),  m_cnt[k] != 0);
         chk($sformatf("dut%0d_pt", k),    get_pt(k),    m_pt[k]);
      end
   end

   task automatic run_one(input int k, input logic [127:0] exp, input string nm);
      int n = 0;
      logic d = 1'b0;
      set_valid(k, 1'b1);
      while (!d && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 1) set_valid(k, 1'b0);
         d = get_done(k);
      end
      chk({nm, "_latency"}, n - 1, nr_k[k]);
      chk({nm, "_pt"}, get_pt(k), exp);
   endtask

   initial begin
      int n;
      int t1;
      int t2;
      logic [255:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
      if4.in_valid = 1'b0; if6.in_valid = 1'b0; if8.in_valid = 1'b0;
      if4.cipherText = 128'h0; if6.cipherText = 128'h0; if8.cipherText = 128'h0;
      if4.keys = '0; if6.keys = '0; if8.keys = '0;
      for (int k = 0; k < 3; k++) cur_exp[k] = 128'h0;

      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end

      repeat (2) @(negedge clk);
      chk("reset_ready", get_ready(0), 1'b1);
      chk("reset_busy", get_busy(0), 1'b0);
      chk("reset_done", get_done(0), 1'b0);
      chk("reset_pt", get_pt(0), 128'h0);
      reset = 1'b0;

      expand(KB, 4); chk("pin_enc_B",  encrypt(PTB, 10), CTB);
      expand(K1, 4); chk("pin_enc_C1", encrypt(PTC, 10), CT1);
      expand(K2, 6); chk("pin_enc_C2", encrypt(PTC, 12), CT2);
      expand(K3, 8); chk("pin_enc_C3", encrypt(PTC, 14), CT3);

      expand(KB, 4); load(0, CTB, PTB); run_one(0, 128'h3243f6a8885a308d313198a2e0370734, "aes128_B");
      expand(K1, 4); load(0, CT1, PTC); run_one(0, 128'h00112233445566778899aabbccddeeff, "aes128_C1");
      expand(K2, 6); load(1, CT2, PTC); run_one(1, 128'h00112233445566778899aabbccddeeff, "aes192_C2");
      expand(K3, 8); load(2, CT3, PTC); run_one(2, 128'h00112233445566778899aabbccddeeff, "aes256_C3");

      // Back-to-back: in_valid held, second vector swapped in during the first done cycle.
      expand(KB, 4); load(0, CTB, PTB); set_valid(0, 1'b1);
      n = 0; t1 = -1; t2 = -1;
      while (t2 < 0 && n < 80) begin
         @(negedge clk);
         n++;
         if (get_done(0)) begin
            if (t1 < 0) begin
               t1 = n;
               chk("b2b_first_pt", get_pt(0), PTB);
               expand(K1, 4); load(0, CT1, PTC);
            end else begin
               t2 = n;
               chk("b2b_second_pt", get_pt(0), PTC);
            end
         end
         if (t1 > 0 && n == t1 + 1) set_valid(0, 1'b0);
         if (t1 > 0 && n == t1 + 4) begin
            if4.cipherText = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
            cur_exp[0] = 128'h0;
            set_valid(0, 1'b1);
         end
         if (t1 > 0 && n == t1 + 5) set_valid(0, 1'b0);
      end
      chk("b2b_first_latency", t1, 11);
      chk("b2b_done_gap", t2 - t1, 11);

      // Asynchronous reset in cycle 5 of a decryption aborts it.
      load(0, CT1, PTC); set_valid(0, 1'b1);
      @(negedge clk); set_valid(0, 1'b0);
      repeat (4) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_pt", get_pt(0), 128'h0);
      chk("abort_ready", get_ready(0), 1'b1);
      chk("abort_busy", get_busy(0), 1'b0);
      chk("abort_done", get_done(0), 1'b0);
      @(negedge clk); reset = 1'b0;
      repeat (3) @(negedge clk);
      run_one(0, 128'h00112233445566778899aabbccddeeff, "after_abort");

      for (int i = 0; i < 1000; i++) begin
         int k;
         k = i % 3;
         key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         pt = {$urandom(), $urandom(), $urandom(), $urandom()};
         expand(key, 4 + 2*k);
         ct = encrypt(pt, nr_k[k]);
         load(k, ct, pt);
         run_one(k, pt, $sformatf("roundtrip%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
